// File: rtl/uart_frame_tx_pkg.sv
// Shared types and constants for the UART framing stage.
package uart_frame_tx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWait
    } frm_state_e;

    localparam logic [7:0]  SYNC_BYTE_DFLT = 8'hA5;
    localparam int unsigned FRM_LEN_SYNC   = 5;
    localparam int unsigned FRM_LEN_NOSYNC = 4;

    // Inverted 8-bit sum of cmd and both payload bytes; carries are dropped.
    function automatic logic [7:0] calc_chk(input logic [7:0] cmd, input logic [15:0] data);
        logic [7:0] sum;
        sum = cmd + data[15:8] + data[7:0];
        return ~sum;
    endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Request/handshake bundle between the command logic, the framer and UART_tx.
interface uart_frame_tx_if;

    logic        snd_frm;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        tx_done;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        busy;
    logic        frm_cmplt;

    // Upstream side: issues requests and returns tx_done.
    modport master (
        output snd_frm, cmd, data, tx_done,
        input  trmt, tx_data, busy, frm_cmplt
    );

    // Framer side.
    modport slave (
        input  snd_frm, cmd, data, tx_done,
        output trmt, tx_data, busy, frm_cmplt
    );

endinterface

// File: rtl/uart_frame_tx.sv
// Serializes one command plus 16-bit payload into a byte frame for UART_tx:
// [sync], cmd, data high, data low, checksum. Paced on tx_done.
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter bit         SYNC_EN   = 1'b1,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_frame_tx_if.slave   bus
);

    localparam int unsigned FrmLen  = SYNC_EN ? FRM_LEN_SYNC : FRM_LEN_NOSYNC;
    localparam logic [2:0]  LastIdx = 3'(FrmLen - 1);

    frm_state_e  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  chk_q, chk_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;
    logic        cmplt_q, cmplt_d;

    // Without a sync byte the index is shifted so both layouts share one decode.
    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [7:0]  c,
                                              input logic [15:0] d,
                                              input logic [7:0]  k);
        logic [2:0] pos;
        logic [7:0] b;
        pos = SYNC_EN ? idx : idx + 3'd1;
        case (pos)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = c;
            3'd2:    b = d[15:8];
            3'd3:    b = d[7:0];
            default: b = k;
        endcase
        return b;
    endfunction

    // Next-state logic; tx_done is only looked at in StWait so a stale one is harmless.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        chk_d     = chk_q;
        tx_data_d = tx_data_q;
        busy_d    = busy_q;
        cmplt_d   = cmplt_q;
        case (state_q)
            StIdle: begin
                if (bus.snd_frm) begin
                    cmd_d     = bus.cmd;
                    data_d    = bus.data;
                    chk_d     = calc_chk(bus.cmd, bus.data);
                    idx_d     = 3'd0;
                    cmplt_d   = 1'b0;
                    busy_d    = 1'b1;
                    tx_data_d = frame_byte(3'd0, bus.cmd, bus.data, chk_d);
                    state_d   = StLoad;
                end
            end
            StLoad: state_d = StWait;
            StWait: begin
                if (bus.tx_done) begin
                    if (idx_q == LastIdx) begin
                        busy_d  = 1'b0;
                        cmplt_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        tx_data_d = frame_byte(idx_q + 3'd1, cmd_q, data_q, chk_q);
                        state_d   = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= 3'd0;
            cmd_q     <= 8'h00;
            data_q    <= 16'h0000;
            chk_q     <= 8'h00;
            tx_data_q <= 8'h00;
            busy_q    <= 1'b0;
            cmplt_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            chk_q     <= chk_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
            cmplt_q   <= cmplt_d;
        end
    end

    // trmt is a pure decode of the state flop, so it cannot glitch.
    assign bus.trmt      = (state_q == StLoad);
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = busy_q;
    assign bus.frm_cmplt = cmplt_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: one sync-framed and one unsynced instance, each fed by
// a behavioural UART_tx model that raises tx_done 10 cycles after trmt.
module tb_uart_frame_tx;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    uart_frame_tx_if ifa ();
    uart_frame_tx_if ifb ();

    uart_frame_tx #(.SYNC_EN(1'b1), .SYNC_BYTE(8'hA5)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    uart_frame_tx #(.SYNC_EN(1'b0), .SYNC_BYTE(8'hA5)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // UART_tx models: log each byte on trmt, clear tx_done there, set it 10 cycles later.
    logic [7:0] bytes_a[$];
    logic [7:0] bytes_b[$];
    int         cnt_a, cnt_b;
    logic       prev_a, prev_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifa.tx_done <= 1'b0;
            cnt_a       <= 0;
            prev_a      <= 1'b0;
        end else begin
            prev_a <= ifa.trmt;
            if (ifa.trmt) begin
                check("trmt_width_a", {31'd0, prev_a}, 32'd0);
                ifa.tx_done <= 1'b0;
                cnt_a       <= 10;
                bytes_a.push_back(ifa.tx_data);
            end else if (cnt_a > 0) begin
                cnt_a <= cnt_a - 1;
                if (cnt_a == 1) ifa.tx_done <= 1'b1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifb.tx_done <= 1'b0;
            cnt_b       <= 0;
            prev_b      <= 1'b0;
        end else begin
            prev_b <= ifb.trmt;
            if (ifb.trmt) begin
                check("trmt_width_b", {31'd0, prev_b}, 32'd0);
                ifb.tx_done <= 1'b0;
                cnt_b       <= 10;
                bytes_b.push_back(ifb.tx_data);
            end else if (cnt_b > 0) begin
                cnt_b <= cnt_b - 1;
                if (cnt_b == 1) ifb.tx_done <= 1'b1;
            end
        end
    end

    typedef struct {
        bit          sel;   // 1 = sync instance, 0 = unsynced instance
        logic [7:0]  cmd;
        logic [15:0] data;
        int unsigned n;
        logic [7:0]  exp [5];
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic get_cmplt(input bit sel);
        return sel ? ifa.frm_cmplt : ifb.frm_cmplt;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? ifa.busy : ifb.busy;
    endfunction

    task automatic send(input bit sel, input logic [7:0] c, input logic [15:0] d);
        tick();
        if (sel) begin
            ifa.snd_frm = 1'b1; ifa.cmd = c; ifa.data = d;
        end else begin
            ifb.snd_frm = 1'b1; ifb.cmd = c; ifb.data = d;
        end
        tick();
        ifa.snd_frm = 1'b0;
        ifb.snd_frm = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        for (int i = 0; i < 400; i++) begin
            if (get_cmplt(sel) && !get_busy(sel)) return;
            tick();
        end
        check("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_bytes_a(input int n);
        for (int i = 0; i < 400; i++) begin
            if (bytes_a.size() >= n) return;
            tick();
        end
        check("byte_timeout", 32'd0, 32'd1);
    endtask

    // Park at the cycle where the last byte's tx_done is visible.
    task automatic wait_last_done_a(input int n);
        for (int i = 0; i < 400; i++) begin
            if (bytes_a.size() == n && ifa.tx_done) return;
            tick();
        end
        check("last_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame_a(input string name, input logic [7:0] e0, input logic [7:0] e1,
                                 input logic [7:0] e2, input logic [7:0] e3,
                                 input logic [7:0] e4);
        logic [7:0] e [5];
        e = '{e0, e1, e2, e3, e4};
        check({name, "_len"}, bytes_a.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_byte%0d", name, i),
                  (i < bytes_a.size()) ? {24'd0, bytes_a[i]} : 32'hxxxx_xxxx, {24'd0, e[i]});
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h05, 16'h1234, 5, '{8'hA5, 8'h05, 8'h12, 8'h34, 8'hB4}};
        vecs[1] = '{1'b1, 8'hA0, 16'hBEEF, 5, '{8'hA5, 8'hA0, 8'hBE, 8'hEF, 8'hB2}};
        vecs[2] = '{1'b1, 8'h00, 16'h0000, 5, '{8'hA5, 8'h00, 8'h00, 8'h00, 8'hFF}};
        vecs[3] = '{1'b0, 8'hFF, 16'hFFFF, 4, '{8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00}};
        vecs[4] = '{1'b0, 8'h01, 16'h0203, 4, '{8'h01, 8'h02, 8'h03, 8'hF9, 8'h00}};

        rst_n = 1'b0;
        ifa.snd_frm = 1'b0; ifa.cmd = 8'h00; ifa.data = 16'h0000;
        ifb.snd_frm = 1'b0; ifb.cmd = 8'h00; ifb.data = 16'h0000;
        repeat (3) tick();
        check("rst_trmt",    {31'd0, ifa.trmt},      32'd0);
        check("rst_tx_data", {24'd0, ifa.tx_data},   32'd0);
        check("rst_busy",    {31'd0, ifa.busy},      32'd0);
        check("rst_cmplt",   {31'd0, ifa.frm_cmplt}, 32'd0);
        check("rst_busy_b",  {31'd0, ifb.busy},      32'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven frames on both instances.
        for (int v = 0; v < 5; v++) begin
            bytes_a.delete();
            bytes_b.delete();
            send(vecs[v].sel, vecs[v].cmd, vecs[v].data);
            wait_done(vecs[v].sel);
            check($sformatf("v%0d_busy", v),  {31'd0, get_busy(vecs[v].sel)},  32'd0);
            check($sformatf("v%0d_cmplt", v), {31'd0, get_cmplt(vecs[v].sel)}, 32'd1);
            if (vecs[v].sel) begin
                check($sformatf("v%0d_len", v), bytes_a.size(), vecs[v].n);
                for (int i = 0; i < 5; i++)
                    check($sformatf("v%0d_byte%0d", v, i),
                          (i < bytes_a.size()) ? {24'd0, bytes_a[i]} : 32'd0,
                          {24'd0, vecs[v].exp[i]});
            end else begin
                check($sformatf("v%0d_len", v), bytes_b.size(), vecs[v].n);
                for (int i = 0; i < 4; i++)
                    check($sformatf("v%0d_byte%0d", v, i),
                          (i < bytes_b.size()) ? {24'd0, bytes_b[i]} : 32'd0,
                          {24'd0, vecs[v].exp[i]});
            end
        end

        // Latency, LOAD width, completion timing, and back-to-back with stale tx_done.
        bytes_a.delete();
        send(1'b1, 8'h05, 16'h1234);
        check("lat_trmt",    {31'd0, ifa.trmt},      32'd1);
        check("lat_tx_data", {24'd0, ifa.tx_data},   32'hA5);
        check("lat_busy",    {31'd0, ifa.busy},      32'd1);
        check("lat_cmplt",   {31'd0, ifa.frm_cmplt}, 32'd0);
        tick();
        check("load_one_cycle", {31'd0, ifa.trmt}, 32'd0);
        wait_last_done_a(5);
        check("pre_end_cmplt", {31'd0, ifa.frm_cmplt}, 32'd0);
        check("pre_end_busy",  {31'd0, ifa.busy},      32'd1);
        tick();
        check("end_cmplt", {31'd0, ifa.frm_cmplt}, 32'd1);
        check("end_busy",  {31'd0, ifa.busy},      32'd0);
        check("stale_done_high", {31'd0, ifa.tx_done}, 32'd1);
        // First IDLE cycle: request accepted despite stale tx_done.
        bytes_a.delete();
        ifa.snd_frm = 1'b1; ifa.cmd = 8'hA0; ifa.data = 16'hBEEF;
        tick();
        ifa.snd_frm = 1'b0;
        check("b2b_trmt",    {31'd0, ifa.trmt},      32'd1);
        check("b2b_cmplt",   {31'd0, ifa.frm_cmplt}, 32'd0);
        check("b2b_tx_data", {24'd0, ifa.tx_data},   32'hA5);
        wait_done(1'b1);
        check_frame_a("b2b", 8'hA5, 8'hA0, 8'hBE, 8'hEF, 8'hB2);

        // Request during a frame is ignored.
        bytes_a.delete();
        send(1'b1, 8'h05, 16'h1234);
        wait_bytes_a(2);
        send(1'b1, 8'h11, 16'h9999);
        wait_done(1'b1);
        check_frame_a("busy_ign", 8'hA5, 8'h05, 8'h12, 8'h34, 8'hB4);
        repeat (30) tick();
        check("busy_ign_no_extra", bytes_a.size(), 32'd5);
        check("busy_ign_cmplt",    {31'd0, ifa.frm_cmplt}, 32'd1);

        // Request in the cycle of the final tx_done is ignored.
        bytes_a.delete();
        send(1'b1, 8'h22, 16'h3344);
        wait_last_done_a(5);
        ifa.snd_frm = 1'b1; ifa.cmd = 8'h77; ifa.data = 16'h7777;
        tick();
        ifa.snd_frm = 1'b0;
        check("fall_ign_busy",  {31'd0, ifa.busy},      32'd0);
        check("fall_ign_cmplt", {31'd0, ifa.frm_cmplt}, 32'd1);
        check("fall_ign_trmt",  {31'd0, ifa.trmt},      32'd0);
        repeat (30) tick();
        check("fall_ign_no_extra", bytes_a.size(), 32'd5);

        // Reset during byte 3's WAIT, then a clean frame.
        bytes_a.delete();
        send(1'b1, 8'h05, 16'h1234);
        wait_bytes_a(3);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_trmt",    {31'd0, ifa.trmt},      32'd0);
        check("midrst_busy",    {31'd0, ifa.busy},      32'd0);
        check("midrst_cmplt",   {31'd0, ifa.frm_cmplt}, 32'd0);
        check("midrst_tx_data", {24'd0, ifa.tx_data},   32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bytes_a.delete();
        send(1'b1, 8'hA0, 16'hBEEF);
        wait_done(1'b1);
        check_frame_a("post_rst", 8'hA5, 8'hA0, 8'hBE, 8'hEF, 8'hB2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
